// File: rtl/hs_tx_pkg.sv
// hs_tx_pkg: shared types and default parameters for the clk1-side
// four-phase sender and its FIFO.
package hs_tx_pkg;

  localparam int N_DEFAULT       = 8;
  localparam int DEPTH_DEFAULT   = 8;
  localparam int TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  function automatic bit isPow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/hs_tx_fifo_if.sv
// hs_tx_fifo_if: producer write port, occupancy status and the four-phase
// link towards the CDC block, bundled for hs_tx_fifo.
interface hs_tx_fifo_if #(
  parameter int N     = hs_tx_pkg::N_DEFAULT,
  parameter int DEPTH = hs_tx_pkg::DEPTH_DEFAULT
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          wrEn;
  logic [N-1:0]  wrData;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          validIn;
  logic [N-1:0]  dataIn;
  logic          ready;
  logic          timeoutErr;

  // master: the sender block; slave: producer plus CDC environment
  modport master (
    input  wrEn, wrData, ready,
    output full, empty, level, validIn, dataIn, timeoutErr
  );

  modport slave (
    output wrEn, wrData, ready,
    input  full, empty, level, validIn, dataIn, timeoutErr
  );

endinterface

// File: rtl/hs_sync_fifo.sv
// hs_sync_fifo: single-clock FIFO with extra-MSB pointers; full/empty/level
// derive from the registered pointers and writes while full are dropped.
module hs_sync_fifo
  import hs_tx_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         push,
  input  logic [N-1:0] pushData,
  input  logic         pop,
  output logic [N-1:0] headData,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);

  logic [N-1:0] mem [DEPTH];
  logic [AW:0]  wrPtr;
  logic [AW:0]  rdPtr;
  logic         doPush;
  logic         doPop;

  // full gates the push even when a pop lands on the same edge
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + (AW + 1)'(1);
      if (doPop)  rdPtr <= rdPtr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
  end

  assign level    = wrPtr - rdPtr;
  assign empty    = (wrPtr == rdPtr);
  assign full     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign headData = mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/hs_tx_fifo.sv
// hs_tx_fifo: buffers producer words and sends them one at a time over the
// four-phase validIn/ready link. Define HS_TX_TIMEOUT_EN to build the ack watchdog.
module hs_tx_fifo
  import hs_tx_pkg::*;
#(
  parameter int N       = N_DEFAULT,
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic          clk1,
  input logic          reset_n,
  hs_tx_fifo_if.master bus
);

  localparam int LW = $clog2(DEPTH) + 1;

  if (!isPow2(DEPTH)) begin : gDepthCheck
    $error("hs_tx_fifo: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 2) begin : gTimeoutCheck
    $error("hs_tx_fifo: TIMEOUT must be >= 2");
  end

  state_t        state;
  logic [N-1:0]  headData;
  logic [N-1:0]  dataReg;
  logic          fifoFull;
  logic          fifoEmpty;
  logic [LW-1:0] fifoLevel;
  logic          launch;
  logic          timeoutHit;

  hs_sync_fifo #(.N(N), .DEPTH(DEPTH)) uFifo (
    .clk      (clk1),
    .rstN     (reset_n),
    .push     (bus.wrEn),
    .pushData (bus.wrData),
    .pop      (launch),
    .headData (headData),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .level    (fifoLevel)
  );

  // A launch is the only pop: the head word moves into dataReg as validIn rises
  assign launch = (state == IDLE) && !fifoEmpty && bus.ready;

  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      dataReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state   <= REQ;
            dataReg <= headData;
          end
        end
        REQ: begin
          if (!bus.ready || timeoutHit) state <= RELEASE;
        end
        RELEASE: begin
          if (bus.ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HS_TX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] toCnt;
  logic          toErr;

  // Cycles spent in REQ with ready still high; the word is abandoned at TIMEOUT
  assign timeoutHit = (state == REQ) && bus.ready && (toCnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      toCnt <= '0;
      toErr <= 1'b0;
    end else begin
      if (launch)
        toCnt <= '0;
      else if ((state == REQ) && bus.ready)
        toCnt <= toCnt + CW'(1);
      if (timeoutHit) toErr <= 1'b1;
    end
  end

  assign bus.timeoutErr = toErr;
`else
  assign timeoutHit     = 1'b0;
  assign bus.timeoutErr = 1'b0;
`endif

  assign bus.validIn = (state == REQ);
  assign bus.dataIn  = dataReg;
  assign bus.full    = fifoFull;
  assign bus.empty   = fifoEmpty;
  assign bus.level   = fifoLevel;

endmodule

// File: tb/tb_hs_tx_fifo.sv
// tb_hs_tx_fifo: random and directed stimulus for hs_tx_fifo, with a queue
// scoreboard and a four-phase ready responder (HS_TX_TIMEOUT_EN aware).
module tb_hs_tx_fifo;

  localparam int N     = 8;
  localparam int DEPTH = 8;
`ifdef HS_TX_TIMEOUT_EN
  localparam int TIMEOUT = 16;
  localparam bit TO_EN   = 1'b1;
`else
  localparam int TIMEOUT = 64;
  localparam bit TO_EN   = 1'b0;
`endif

  localparam int RSP_NORMAL    = 0;
  localparam int RSP_HOLD_LOW  = 1;
  localparam int RSP_STAY_HIGH = 2;

  logic clk1 = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk1 = ~clk1;

  hs_tx_fifo_if #(.N(N), .DEPTH(DEPTH)) bus ();

  hs_tx_fifo #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk1    (clk1),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int nChecks = 0;
  int nFail   = 0;
  bit monEn   = 1'b0;
  int rspMode = RSP_NORMAL;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready responder: drop 3 cycles after validIn rises, restore 4 after it falls
  int hiCnt = 0;
  int loCnt = 0;
  always @(negedge clk1) begin
    if (!reset_n) begin
      bus.ready = 1'b1; hiCnt = 0; loCnt = 0;
    end else if (rspMode == RSP_HOLD_LOW) begin
      bus.ready = 1'b0; hiCnt = 0; loCnt = 0;
    end else if (rspMode == RSP_STAY_HIGH) begin
      bus.ready = 1'b1; hiCnt = 0; loCnt = 0;
    end else if (bus.ready) begin
      loCnt = 0;
      if (bus.validIn) begin
        hiCnt++;
        if (hiCnt == 3) begin bus.ready = 1'b0; hiCnt = 0; end
      end else hiCnt = 0;
    end else begin
      hiCnt = 0;
      if (!bus.validIn) begin
        loCnt++;
        if (loCnt == 4) begin bus.ready = 1'b1; loCnt = 0; end
      end else loCnt = 0;
    end
  end

  // Inputs as the DUT sees them at each rising edge
  logic         capWrEn = 1'b0;
  logic         capReady = 1'b1;
  logic [N-1:0] capData = '0;
  always @(posedge clk1) begin
    capWrEn  = bus.wrEn;
    capData  = bus.wrData;
    capReady = bus.ready;
  end

  // Reference model: accepted words queue up; a launch takes the oldest one
  logic [N-1:0] expQ[$];
  int           mLevel = 0;
  bit           mValid = 1'b0;
  bit           mRelease = 1'b0;
  int           mReqCycles = 0;
  logic [N-1:0] mData = '0;
  bit           mErr = 1'b0;
  int           preLevel;
  bit           fallNow;
  bit           launchNow;

  always @(negedge clk1) begin
    if (!monEn || !reset_n) begin
      expQ.delete();
      mLevel = 0; mValid = 1'b0; mRelease = 1'b0;
      mReqCycles = 0; mData = '0; mErr = 1'b0;
    end else begin
      preLevel  = mLevel;
      fallNow   = mValid && (!capReady || (TO_EN && mReqCycles == TIMEOUT));
      launchNow = !mValid && !mRelease && capReady && (preLevel > 0);
      if (mRelease && capReady) mRelease = 1'b0;
      if (launchNow) begin
        mData = expQ.pop_front();
        mLevel--;
        mValid = 1'b1;
        mReqCycles = 1;
      end else if (fallNow) begin
        if (capReady) mErr = 1'b1;
        mValid = 1'b0;
        mRelease = 1'b1;
      end else if (mValid) begin
        mReqCycles++;
      end
      if (capWrEn && preLevel < DEPTH) begin
        expQ.push_back(capData);
        mLevel++;
      end
      chk("validIn",    32'(bus.validIn),    32'(mValid));
      chk("dataIn",     32'(bus.dataIn),     32'(mData));
      chk("level",      32'(bus.level),      32'(mLevel));
      chk("full",       32'(bus.full),       32'(mLevel == DEPTH));
      chk("empty",      32'(bus.empty),      32'(mLevel == 0));
      chk("timeoutErr", 32'(bus.timeoutErr), 32'(mErr));
    end
  end

  task automatic wr(input logic [N-1:0] d);
    bus.wrEn   = 1'b1;
    bus.wrData = d;
    @(negedge clk1);
    bus.wrEn   = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while (!(bus.empty && !bus.validIn && bus.ready) && n < budget) begin
      @(negedge clk1);
      n++;
    end
    chk(name, 32'(n < budget), 32'(1));
    repeat (3) @(negedge clk1);
  endtask

  initial begin
    bus.wrEn   = 1'b0;
    bus.wrData = '0;
    reset_n    = 1'b0;
    repeat (3) @(negedge clk1);
    chk("rst validIn",    32'(bus.validIn),    32'(0));
    chk("rst dataIn",     32'(bus.dataIn),     32'(0));
    chk("rst full",       32'(bus.full),       32'(0));
    chk("rst empty",      32'(bus.empty),      32'(1));
    chk("rst level",      32'(bus.level),      32'(0));
    chk("rst timeoutErr", 32'(bus.timeoutErr), 32'(0));
    reset_n = 1'b1;
    repeat (2) @(negedge clk1);
    monEn = 1'b1;
    @(negedge clk1);

    // Single word: validIn one edge after the commit
    wr(8'hAA);
    chk("single launch wait", 32'(bus.validIn), 32'(0));
    chk("single level", 32'(bus.level), 32'(1));
    @(negedge clk1);
    chk("single validIn", 32'(bus.validIn), 32'(1));
    chk("single dataIn", 32'(bus.dataIn), 32'(8'hAA));
    waitDrain("single drain", 200);
    chk("single level end", 32'(bus.level), 32'(0));

    // Burst of 9 with the link stalled: the ninth write is dropped
    rspMode = RSP_HOLD_LOW;
    repeat (2) @(negedge clk1);
    for (int i = 1; i <= 9; i++) begin
      bus.wrEn   = 1'b1;
      bus.wrData = N'(i);
      @(negedge clk1);
      if (i == 8) chk("burst full", 32'(bus.full), 32'(1));
    end
    bus.wrEn = 1'b0;
    chk("burst level", 32'(bus.level), 32'(DEPTH));
    rspMode = RSP_NORMAL;
    waitDrain("burst drain", 600);

    // Ready held low blocks launch
    rspMode = RSP_HOLD_LOW;
    repeat (2) @(negedge clk1);
    wr(8'h10);
    wr(8'h11);
    repeat (4) @(negedge clk1);
    chk("hold validIn", 32'(bus.validIn), 32'(0));
    chk("hold level", 32'(bus.level), 32'(2));
    rspMode = RSP_NORMAL;
    waitDrain("hold drain", 200);

    // Wrap-around: 20 writes kept at level <= 3
    for (int i = 0; i < 20; i++) begin
      int n = 0;
      while (bus.level > 2 && n < 200) begin
        @(negedge clk1);
        n++;
      end
      wr(N'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk1);
    end
    waitDrain("wrap drain", 400);

    // Random writes against the normal responder, overflowing at times
    for (int i = 0; i < 120; i++) begin
      bus.wrEn   = 1'($urandom_range(0, 1));
      bus.wrData = N'($urandom);
      @(negedge clk1);
    end
    bus.wrEn = 1'b0;
    waitDrain("random drain", 800);

    // Reset asserted while a word is in REQ
    wr(8'h5A);
    wr(8'h5B);
    begin
      int n = 0;
      while (!bus.validIn && n < 50) begin
        @(negedge clk1);
        n++;
      end
      chk("rst-mid reached REQ", 32'(bus.validIn), 32'(1));
    end
    monEn = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst-mid validIn async", 32'(bus.validIn), 32'(0));
    repeat (2) @(negedge clk1);
    reset_n = 1'b1;
    @(negedge clk1);
    chk("rst-mid empty", 32'(bus.empty), 32'(1));
    chk("rst-mid level", 32'(bus.level), 32'(0));
    chk("rst-mid dataIn", 32'(bus.dataIn), 32'(0));
    @(negedge clk1);
    monEn = 1'b1;
    repeat (2) @(negedge clk1);

`ifdef HS_TX_TIMEOUT_EN
    // Responder never acknowledges: first word times out, second goes through
    rspMode = RSP_STAY_HIGH;
    repeat (2) @(negedge clk1);
    wr(8'hC1);
    wr(8'hC2);
    begin
      int n = 0;
      while (!bus.timeoutErr && n < 60) begin
        @(negedge clk1);
        n++;
      end
      chk("timeout flag", 32'(bus.timeoutErr), 32'(1));
      chk("timeout validIn", 32'(bus.validIn), 32'(0));
    end
    rspMode = RSP_NORMAL;
    begin
      int n = 0;
      while (!bus.validIn && n < 20) begin
        @(negedge clk1);
        n++;
      end
      chk("timeout next dataIn", 32'(bus.dataIn), 32'(8'hC2));
    end
    waitDrain("timeout drain", 200);
    chk("timeout sticky", 32'(bus.timeoutErr), 32'(1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
